seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 54 +++++
 rtl/seq_alu_mdu.sv | 86 ++++++++
 rtl/seq_alu.sv | 137 +++++++++++++
 tb/tb_seq_alu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: constants and types shared by seq_alu and seq_alu_mdu.
//   - 5-bit opcode constants
//   - FSM state enum (IDLE/BUSY/DONE)
//   - multiply/divide result select enum
//   - helpers that classify multiply/divide opcodes
package seq_alu_pkg;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_AND   = 5'b00111;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_XOR   = 5'b00100;
  localparam logic [4:0] OP_SLT   = 5'b01100;
  localparam logic [4:0] OP_SLTU  = 5'b01110;
  localparam logic [4:0] OP_SLL   = 5'b00001;
  localparam logic [4:0] OP_SRL   = 5'b00101;
  localparam logic [4:0] OP_SRA   = 5'b01011;
  localparam logic [4:0] OP_MUL   = 5'b10000;
  localparam logic [4:0] OP_MULHU = 5'b10011;
  localparam logic [4:0] OP_DIV   = 5'b10100;
  localparam logic [4:0] OP_DIVU  = 5'b10101;
  localparam logic [4:0] OP_REM   = 5'b10110;
  localparam logic [4:0] OP_REMU  = 5'b10111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_MUL_LO = 2'd0,
    SEL_MUL_HI = 2'd1,
    SEL_QUO    = 2'd2,
    SEL_REM    = 2'd3
  } res_sel_t;

  function automatic logic is_mdu_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIV) ||
           (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic res_sel_t mdu_sel(input logic [4:0] op);
    res_sel_t s;
    case (op)
      OP_MULHU:          s = SEL_MUL_HI;
      OP_DIV, OP_DIVU:   s = SEL_QUO;
      OP_REM, OP_REMU:   s = SEL_REM;
      default:           s = SEL_MUL_LO;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_alu_mdu.sv
// seq_alu_mdu: iterative multiply/divide datapath, one step per cycle.
//   clk    : clock
//   load   : capture operands/opcode and clear the accumulator
//   step   : perform one shift-add or restoring-divide iteration
//   op     : opcode (MUL, MULHU, DIV, DIVU, REM, REMU)
//   a, b   : operands
//   result : selected result, valid after XLEN steps
// Shared register pair {acc, lo}:
//   multiply: lo starts as multiplier, ends as low product; acc ends as high product
//   divide  : lo starts as dividend, ends as quotient; acc ends as remainder
module seq_alu_mdu
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            load,
  input  logic            step,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] acc, lo, opb;
  logic            is_div, neg_q, neg_r;
  res_sel_t        sel;

  logic [XLEN-1:0] acc_n, lo_n;
  logic [XLEN:0]   sh, diff, sum;

  // Signed divide works on magnitudes; signs are restored on the way out.
  logic sgn, a_neg, b_neg;
  assign sgn   = (op == OP_DIV) || (op == OP_REM);
  assign a_neg = sgn && a[XLEN-1];
  assign b_neg = sgn && b[XLEN-1];

  always_comb begin
    acc_n = acc;
    lo_n  = lo;
    sh    = '0;
    diff  = '0;
    sum   = '0;
    if (is_div) begin
      sh   = {acc, lo[XLEN-1]};
      diff = sh - {1'b0, opb};
      // Borrow out of bit XLEN means the trial subtraction went negative.
      if (!diff[XLEN]) begin
        acc_n = diff[XLEN-1:0];
        lo_n  = {lo[XLEN-2:0], 1'b1};
      end else begin
        acc_n = sh[XLEN-1:0];
        lo_n  = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      sum   = {1'b0, acc} + {1'b0, (lo[0] ? opb : '0)};
      acc_n = sum[XLEN:1];
      lo_n  = {sum[0], lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      acc    <= '0;
      lo     <= a_neg ? -a : a;
      opb    <= b_neg ? -b : b;
      is_div <= op[2];
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      sel    <= mdu_sel(op);
    end else if (step) begin
      acc <= acc_n;
      lo  <= lo_n;
    end
  end

  always_comb begin
    case (sel)
      SEL_MUL_HI: result = acc;
      SEL_QUO:    result = neg_q ? -lo : lo;
      SEL_REM:    result = neg_r ? -acc : acc;
      default:    result = lo;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready request and response handshakes.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : request handshake (ready only in IDLE)
//   in_a, in_b, in_op    : operands and 5-bit opcode
//   out_valid/out_ready  : response handshake (valid only in DONE)
//   out_result, out_zero : result and result==0 flag
// Optional macro SEQ_ALU_MDU_EN compiles in the iterative multiply/divide unit;
// without it the 10xxx opcodes behave as undefined (result 0, latency 1).
// Operands are registered on acceptance; the result register is loaded on the
// first DONE cycle, so out_valid rises one edge after entering DONE.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, alu_res, mdu_res, fin_res, result_q;
  logic            multi, multi_q, res_vld_q, zero_q, accept, resp;
  logic [SW-1:0]   shamt;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE) && res_vld_q;
  assign accept     = in_valid && in_ready;
  assign resp       = out_valid && out_ready;
  assign out_result = result_q;
  assign out_zero   = zero_q;

`ifdef SEQ_ALU_MDU_EN
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  logic in_div_zero, in_ovf;
  assign in_div_zero = (in_b == '0);
  assign in_ovf      = (in_a == SMIN) && (in_b == '1) &&
                       ((in_op == OP_DIV) || (in_op == OP_REM));
  // Divide special cases resolve in one cycle through the ALU path.
  assign multi = is_mdu_op(in_op) && !(in_op[2] && (in_div_zero || in_ovf));

  seq_alu_mdu #(.XLEN(XLEN)) u_mdu (
    .clk    (clk),
    .load   (accept && multi),
    .step   (state_q == BUSY),
    .op     (in_op),
    .a      (in_a),
    .b      (in_b),
    .result (mdu_res)
  );
`else
  assign multi   = 1'b0;
  assign mdu_res = '0;
`endif

  assign shamt = b_q[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
      OP_SLL:  alu_res = a_q << shamt;
      OP_SRL:  alu_res = a_q >> shamt;
      OP_SRA:  alu_res = $signed(a_q) >>> shamt;
`ifdef SEQ_ALU_MDU_EN
      // Only reached for divide-by-zero or signed overflow.
      OP_DIV, OP_DIVU: alu_res = (b_q == '0) ? '1 : a_q;
      OP_REM, OP_REMU: alu_res = (b_q == '0) ? a_q : '0;
`endif
      default: alu_res = '0;
    endcase
  end

  assign fin_res = multi_q ? mdu_res : alu_res;

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_n = multi ? BUSY : DONE;
      BUSY:    if (cnt_q == CNT_LAST) state_n = DONE;
      DONE:    if (resp) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      multi_q   <= 1'b0;
      res_vld_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      if (accept) begin
        op_q      <= in_op;
        a_q       <= in_a;
        b_q       <= in_b;
        multi_q   <= multi;
        cnt_q     <= '0;
        res_vld_q <= 1'b0;
      end
      if (state_q == BUSY) cnt_q <= cnt_q + 1'b1;
      if ((state_q == DONE) && !res_vld_q) begin
        result_q  <= fin_res;
        zero_q    <= (fin_res == '0);
        res_vld_q <= 1'b1;
      end
      if (resp) res_vld_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (XLEN=32). Expected results and
// latencies come from a behavioural model; SEQ_ALU_MDU_EN selects whether
// multiply/divide opcodes are expected to work or to read as undefined.
module tb_seq_alu;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [XLEN-1:0] in_a, in_b, out_result;
  logic [4:0]      in_op;

  typedef struct {
    string       tag;
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  seq_alu #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output int lat);
    logic [63:0] p;
    int sa, sb;
    sa = a; sb = b;
    p = {32'b0, a} * {32'b0, b};
    r = '0; lat = 1;
    case (op)
      5'b00000: r = a + b;
      5'b01010: r = a - b;
      5'b00111: r = a & b;
      5'b00110: r = a | b;
      5'b00100: r = a ^ b;
      5'b01100: r = (sa < sb) ? 32'd1 : 32'd0;
      5'b01110: r = (a < b) ? 32'd1 : 32'd0;
      5'b00001: r = a << b[4:0];
      5'b00101: r = a >> b[4:0];
      5'b01011: r = $signed(a) >>> b[4:0];
`ifdef SEQ_ALU_MDU_EN
      5'b10000: begin r = p[31:0];  lat = 33; end
      5'b10011: begin r = p[63:32]; lat = 33; end
      5'b10100: if (b == 0) r = '1;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                else begin r = sa / sb; lat = 33; end
      5'b10101: if (b == 0) r = '1; else begin r = a / b; lat = 33; end
      5'b10110: if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = '0;
                else begin r = sa % sb; lat = 33; end
      5'b10111: if (b == 0) r = a; else begin r = a % b; lat = 33; end
`endif
      default:  r = '0;
    endcase
  endfunction

  // Issue one request, wait for the response, optionally stall it for
  // `hold` cycles, then take it.
  task automatic run_op(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e, g;
    int k;
    e.tag = tag;
    model(op, a, b, e.res, e.lat);
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_out_valid"}, out_valid, 1);
    if (out_valid && sb_q.size() > 0) begin
      g = sb_q.pop_front();
      chk({g.tag, "_result"}, out_result, g.res);
      chk({g.tag, "_zero"}, out_zero, (g.res == 0));
      chk({g.tag, "_latency"}, k, g.lat);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk({g.tag, "_hold_result"}, out_result, g.res);
        chk({g.tag, "_hold_in_ready"}, in_ready, 0);
        chk({g.tag, "_hold_valid"}, out_valid, 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({g.tag, "_released"}, out_valid, 0);
      chk({g.tag, "_idle"}, in_ready, 1);
    end else begin
      sb_q.delete();
    end
  endtask

  logic [4:0] rnd_ops [10];
  int seen;

  initial begin
    rnd_ops = '{5'b00000, 5'b01010, 5'b00111, 5'b00110, 5'b00100,
                5'b01100, 5'b01110, 5'b00001, 5'b00101, 5'b01011};
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    in_a = 32'h1234; in_b = 32'h1; in_op = 5'b00000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_zero", out_zero, 1);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_no_resp", out_valid, 0);

    run_op("add_wrap", 5'b00000, 32'hFFFFFFFF, 32'h1, 0);
    run_op("sub",      5'b01010, 32'd3, 32'd5, 0);
    run_op("and",      5'b00111, 32'hF0F0FF00, 32'h0FF0F0F0, 0);
    run_op("or",       5'b00110, 32'hF0000000, 32'h0000000F, 0);
    run_op("xor",      5'b00100, 32'hAAAA5555, 32'hFFFF0000, 0);
    run_op("slt",      5'b01100, 32'hFFFFFFFF, 32'h1, 0);
    run_op("sltu",     5'b01110, 32'hFFFFFFFF, 32'h1, 0);
    run_op("sll",      5'b00001, 32'h1, 32'h3F, 0);
    run_op("srl",      5'b00101, 32'h80000000, 32'h21, 0);
    run_op("sra",      5'b01011, 32'h80000000, 32'h24, 0);
    run_op("undef",    5'b01111, 32'h12345678, 32'h1, 0);
    run_op("undef_mdu",5'b10001, 32'h12345678, 32'h2, 0);
    run_op("mul",      5'b10000, 32'h12345, 32'h6789, 0);
    run_op("mulhu",    5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 3);
    run_op("div",      5'b10100, 32'hFFFFFFF9, 32'd2, 0);
    run_op("rem",      5'b10110, 32'hFFFFFFF9, 32'd2, 0);
    run_op("divu",     5'b10101, 32'd100, 32'd7, 0);
    run_op("remu",     5'b10111, 32'd100, 32'd7, 0);
    run_op("divu_z",   5'b10101, 32'd5, 32'd0, 0);
    run_op("remu_z",   5'b10111, 32'd5, 32'd0, 0);
    run_op("div_ovf",  5'b10100, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op("rem_ovf",  5'b10110, 32'h80000000, 32'hFFFFFFFF, 0);
    for (int i = 0; i < 8; i++)
      run_op("rnd", rnd_ops[$urandom_range(9)], $urandom, $urandom, 0);

    // Reset ten cycles into a divide must drop the operation entirely.
    @(negedge clk);
    in_valid = 1'b1; in_op = 5'b10100; in_a = 32'd100; in_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", out_result, 0);
    chk("abort_zero", out_zero, 1);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    chk("abort_no_resp", seen, 0);

    run_op("after_abort", 5'b00000, 32'd40, 32'd2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
